vadd_float_arbiter: RTL and testbench
=====================================

Name: vadd_float_arbiter

Overview:
- Shares one floating-point adder (AXI4-Stream a/b operands in, result out) between two requesters. Each requester has its own a/b operand stream pair and c result stream.
- Arbitration is round-robin at packet granularity. A packet ends on the a-stream beat with tlast.
- A tag FIFO records the owner of every issued beat, so in-order adder results are routed back to the correct requester.
- Sits between the per-requester input FIFOs and the single shared adder instance in the vadd kernel.

Parameters:
C_AXIS_TDATA_WIDTH, 32, data width of all streams
C_TAG_DEPTH, 32, max beats in flight inside the adder; power of two, >= adder latency + 2

Ports:
ap_aclk  in  1  clock
ap_areset  in  1  synchronous active-high reset
s0_axis_a_tvalid/tready/tdata/tlast  in/out/in/in  1/1/W/1  requester 0 operand a
s0_axis_b_tvalid/tready/tdata/tlast  in/out/in/in  1/1/W/1  requester 0 operand b
m0_axis_c_tvalid/tready/tdata/tlast  out/in/out/out  1/1/W/1  requester 0 result
s1_axis_a_*, s1_axis_b_*, m1_axis_c_*  same as above  requester 1
m_axis_fa_tvalid/tready/tdata/tlast  out/in/out/out  1/1/W/1  to adder operand a
m_axis_fb_tvalid/tready/tdata/tlast  out/in/out/out  1/1/W/1  to adder operand b
s_axis_fr_tvalid/tready/tdata/tlast  in/out/in/in  1/1/W/1  from adder result

Behaviour:
Interface and reset:
- Single clock ap_aclk; ap_areset is synchronous and active-high.
- Reset: FSM=IDLE, rr_ptr=0, tag FIFO empty, fa_done=fb_done=0, err=0.
- All tvalid/tready outputs are 0 during and after reset until the conditions below hold.

FSM states:
- IDLE: if any requester has a_tvalid&b_tvalid, grant it. If both request, grant rr_ptr. Move to BUSY.
- BUSY: the granted requester owns the adder.
- On completion of a beat whose a.tlast=1: toggle rr_ptr to the other requester and return to IDLE (one idle cycle between packets).
- A request on the non-granted requester never preempts the current packet.

Issue (BUSY):
- m_axis_fa_tvalid = granted a_tvalid & b_tvalid & ~tag_full & ~fa_done.
- m_axis_fb_tvalid is the same expression with ~fb_done.
- tvalid never depends on adder tready.
- fa_done/fb_done latch the per-side handshake when the adder accepts one side before the other.
- Beat completes when (fa_done | fa handshake) & (fb_done | fb handshake). In that cycle:
  - granted s_a_tready=s_b_tready=1;
  - push requester id into the tag FIFO;
  - clear fa_done/fb_done.
- At all other times requester treadies are 0.
- tdata/tlast pass through combinationally. fb_tlast carries b.tlast.

Return path:
- Tag FIFO head selects the output.
- m{head}_axis_c_tvalid = s_axis_fr_tvalid & ~tag_empty.
- s_axis_fr_tready = m{head}_axis_c_tready & ~tag_empty.
- Pop the tag on the fr handshake. Results for different requesters leave in issue order.
- Other output's tvalid=0.

Latency and boundaries:
- Zero-cycle combinational path through the arbiter in both directions.
- Tag FIFO full: issue stalls; results still drain.
- Push and pop in the same cycle with FIFO full: legal, count unchanged.
- Result arrives with tag FIFO empty: fr_tready=0 (result held, never dropped).
- Reset mid-packet: in-flight tags are discarded; the adder must be reset in the same cycle.
- a.tlast != b.tlast on a completed beat: packet end still follows a.tlast.

Optional Feature:
- Macro VADD_FLOAT_ARBITER_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0), sticky until ap_areset.
  - err is set on a completed beat with a.tlast != b.tlast.
  - err is set when s_axis_fr_tvalid=1 while the tag FIFO is empty.
- Undefined: no err port and no extra logic; behaviour otherwise identical.

Test Plan:
- Single requester: r0 sends 4 beats a=1.0..4.0, b=0.5; r1 idle. Required: m0_c = 1.5, 2.5, 3.5, 4.5 with tlast on beat 4; m1_c_tvalid never 1.
- Contention: both send 3-beat packets at t=0, 2 packets each. Required: grant order r0,r1,r0,r1; every result reaches its owner in order.
- Adder backpressure: fa_tready=1, fb_tready=0 for 5 cycles. Required: fa_tvalid drops after the handshake (fa_done=1); requester tready stays 0 until fb accepts; exactly one tag pushed.
- Tag full: C_TAG_DEPTH=4, m0_c_tready=0. Required: exactly 4 beats issued; fa_tvalid=0 until 1 result drains; no loss.
- Interleaved drain: r0 and r1 results in flight, m1_c_tready=0. Required: fr_tready=0 when head tag is 1; r0 results behind it wait (in-order, no bypass).
- ERR_EN: a.tlast=1, b.tlast=0 on beat 2. Required: err=1 from the cycle after completion, held until reset; arbitration switches to r1.

Source files
------------

// File: rtl/vadd_float_arbiter.sv
// Round-robin, packet-granular sharing of one AXI4-Stream float adder between two requesters.
// Optional sticky protocol error flag (port err) is built when VADD_FLOAT_ARBITER_ERR_EN is defined.
`timescale 1ns/1ps

module vadd_float_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_TAG_DEPTH        = 32
) (
    input  logic                          ap_aclk,
    input  logic                          ap_areset,

    input  logic                          s0_axis_a_tvalid,
    output logic                          s0_axis_a_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s0_axis_a_tdata,
    input  logic                          s0_axis_a_tlast,
    input  logic                          s0_axis_b_tvalid,
    output logic                          s0_axis_b_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s0_axis_b_tdata,
    input  logic                          s0_axis_b_tlast,
    output logic                          m0_axis_c_tvalid,
    input  logic                          m0_axis_c_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m0_axis_c_tdata,
    output logic                          m0_axis_c_tlast,

    input  logic                          s1_axis_a_tvalid,
    output logic                          s1_axis_a_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s1_axis_a_tdata,
    input  logic                          s1_axis_a_tlast,
    input  logic                          s1_axis_b_tvalid,
    output logic                          s1_axis_b_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s1_axis_b_tdata,
    input  logic                          s1_axis_b_tlast,
    output logic                          m1_axis_c_tvalid,
    input  logic                          m1_axis_c_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m1_axis_c_tdata,
    output logic                          m1_axis_c_tlast,

    output logic                          m_axis_fa_tvalid,
    input  logic                          m_axis_fa_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_fa_tdata,
    output logic                          m_axis_fa_tlast,
    output logic                          m_axis_fb_tvalid,
    input  logic                          m_axis_fb_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_fb_tdata,
    output logic                          m_axis_fb_tlast,

    input  logic                          s_axis_fr_tvalid,
    output logic                          s_axis_fr_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_fr_tdata,
    input  logic                          s_axis_fr_tlast
`ifdef VADD_FLOAT_ARBITER_ERR_EN
    ,
    output logic                          err
`endif
);

    localparam int AW = $clog2(C_TAG_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   w_grant_nxt;
    logic   r_rr_ptr;
    logic   w_rr_ptr_nxt;
    logic   r_fa_done;
    logic   w_fa_done_nxt;
    logic   r_fb_done;
    logic   w_fb_done_nxt;

    logic          r_tag_mem [C_TAG_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   w_tag_cnt;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic          w_tag_head;
    logic          w_push;
    logic          w_pop;

    logic                          w_req0;
    logic                          w_req1;
    logic                          w_a_tvalid;
    logic                          w_b_tvalid;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_a_tdata;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_b_tdata;
    logic                          w_a_tlast;
    logic                          w_b_tlast;
    logic                          w_issue;
    logic                          w_fa_valid;
    logic                          w_fb_valid;
    logic                          w_fa_hs;
    logic                          w_fb_hs;
    logic                          w_beat_done;

    // Operand path: the granted requester's streams are muxed straight onto the adder.
    assign w_req0     = s0_axis_a_tvalid & s0_axis_b_tvalid;
    assign w_req1     = s1_axis_a_tvalid & s1_axis_b_tvalid;
    assign w_a_tvalid = r_grant ? s1_axis_a_tvalid : s0_axis_a_tvalid;
    assign w_b_tvalid = r_grant ? s1_axis_b_tvalid : s0_axis_b_tvalid;
    assign w_a_tdata  = r_grant ? s1_axis_a_tdata  : s0_axis_a_tdata;
    assign w_b_tdata  = r_grant ? s1_axis_b_tdata  : s0_axis_b_tdata;
    assign w_a_tlast  = r_grant ? s1_axis_a_tlast  : s0_axis_a_tlast;
    assign w_b_tlast  = r_grant ? s1_axis_b_tlast  : s0_axis_b_tlast;

    // Both operands must be present before either side is offered, so the
    // adder never sees a lone operand from a beat that could still change owner.
    assign w_issue     = (r_state == BUSY) & w_a_tvalid & w_b_tvalid & ~w_tag_full;
    assign w_fa_valid  = w_issue & ~r_fa_done;
    assign w_fb_valid  = w_issue & ~r_fb_done;
    assign w_fa_hs     = w_fa_valid & m_axis_fa_tready;
    assign w_fb_hs     = w_fb_valid & m_axis_fb_tready;
    assign w_beat_done = w_issue & (r_fa_done | w_fa_hs) & (r_fb_done | w_fb_hs);

    assign m_axis_fa_tvalid = w_fa_valid;
    assign m_axis_fa_tdata  = w_a_tdata;
    assign m_axis_fa_tlast  = w_a_tlast;
    assign m_axis_fb_tvalid = w_fb_valid;
    assign m_axis_fb_tdata  = w_b_tdata;
    assign m_axis_fb_tlast  = w_b_tlast;

    assign s0_axis_a_tready = w_beat_done & ~r_grant;
    assign s0_axis_b_tready = w_beat_done & ~r_grant;
    assign s1_axis_a_tready = w_beat_done &  r_grant;
    assign s1_axis_b_tready = w_beat_done &  r_grant;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_fa_done_nxt = r_fa_done;
        w_fb_done_nxt = r_fb_done;
        case (r_state)
            IDLE: begin
                if (w_req0 | w_req1) begin
                    w_state_nxt = BUSY;
                    if (w_req0 & w_req1) begin
                        w_grant_nxt = r_rr_ptr;
                    end else begin
                        w_grant_nxt = w_req1;
                    end
                end
            end
            BUSY: begin
                if (w_beat_done) begin
                    w_fa_done_nxt = 1'b0;
                    w_fb_done_nxt = 1'b0;
                    if (w_a_tlast) begin
                        w_rr_ptr_nxt = ~r_grant;
                        w_state_nxt  = IDLE;
                    end
                end else begin
                    if (w_fa_hs) begin
                        w_fa_done_nxt = 1'b1;
                    end
                    if (w_fb_hs) begin
                        w_fb_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_fa_done <= 1'b0;
            r_fb_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_fa_done <= w_fa_done_nxt;
            r_fb_done <= w_fb_done_nxt;
        end
    end

    // Tag FIFO: one owner bit per beat in flight; pointers carry an extra wrap bit.
    assign w_tag_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_tag_full  = (w_tag_cnt == (AW+1)'(C_TAG_DEPTH));
    assign w_tag_empty = (w_tag_cnt == '0);
    assign w_tag_head  = r_tag_mem[r_rd_ptr[AW-1:0]];
    assign w_push      = w_beat_done;
    assign w_pop       = s_axis_fr_tvalid & s_axis_fr_tready;

    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_aclk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr[AW-1:0]] <= r_grant;
        end
    end

    // Return path: the head tag steers results; a result with no tag is held, never dropped.
    assign s_axis_fr_tready = ~w_tag_empty & (w_tag_head ? m1_axis_c_tready : m0_axis_c_tready);
    assign m0_axis_c_tvalid = s_axis_fr_tvalid & ~w_tag_empty & ~w_tag_head;
    assign m1_axis_c_tvalid = s_axis_fr_tvalid & ~w_tag_empty &  w_tag_head;
    assign m0_axis_c_tdata  = s_axis_fr_tdata;
    assign m0_axis_c_tlast  = s_axis_fr_tlast;
    assign m1_axis_c_tdata  = s_axis_fr_tdata;
    assign m1_axis_c_tlast  = s_axis_fr_tlast;

`ifdef VADD_FLOAT_ARBITER_ERR_EN
    logic r_err;

    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            r_err <= 1'b0;
        end else if ((w_beat_done & (w_a_tlast ^ w_b_tlast)) |
                     (s_axis_fr_tvalid & w_tag_empty)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_vadd_float_arbiter.sv
// Scoreboard bench for vadd_float_arbiter with a behavioural two-channel float adder model.
`timescale 1ns/1ps

module tb_vadd_float_arbiter;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic ap_aclk = 1'b0;
    logic ap_areset;
    always #5 ap_aclk = ~ap_aclk;

    logic         s0_axis_a_tvalid, s0_axis_a_tready, s0_axis_a_tlast;
    logic [W-1:0] s0_axis_a_tdata;
    logic         s0_axis_b_tvalid, s0_axis_b_tready, s0_axis_b_tlast;
    logic [W-1:0] s0_axis_b_tdata;
    logic         m0_axis_c_tvalid, m0_axis_c_tready, m0_axis_c_tlast;
    logic [W-1:0] m0_axis_c_tdata;
    logic         s1_axis_a_tvalid, s1_axis_a_tready, s1_axis_a_tlast;
    logic [W-1:0] s1_axis_a_tdata;
    logic         s1_axis_b_tvalid, s1_axis_b_tready, s1_axis_b_tlast;
    logic [W-1:0] s1_axis_b_tdata;
    logic         m1_axis_c_tvalid, m1_axis_c_tready, m1_axis_c_tlast;
    logic [W-1:0] m1_axis_c_tdata;
    logic         m_axis_fa_tvalid, m_axis_fa_tready, m_axis_fa_tlast;
    logic [W-1:0] m_axis_fa_tdata;
    logic         m_axis_fb_tvalid, m_axis_fb_tready, m_axis_fb_tlast;
    logic [W-1:0] m_axis_fb_tdata;
    logic         s_axis_fr_tvalid, s_axis_fr_tready, s_axis_fr_tlast;
    logic [W-1:0] s_axis_fr_tdata;
`ifdef VADD_FLOAT_ARBITER_ERR_EN
    logic         err;
`endif

    vadd_float_arbiter #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_TAG_DEPTH       (DEPTH)
    ) dut (
        .ap_aclk          (ap_aclk),
        .ap_areset        (ap_areset),
        .s0_axis_a_tvalid (s0_axis_a_tvalid),
        .s0_axis_a_tready (s0_axis_a_tready),
        .s0_axis_a_tdata  (s0_axis_a_tdata),
        .s0_axis_a_tlast  (s0_axis_a_tlast),
        .s0_axis_b_tvalid (s0_axis_b_tvalid),
        .s0_axis_b_tready (s0_axis_b_tready),
        .s0_axis_b_tdata  (s0_axis_b_tdata),
        .s0_axis_b_tlast  (s0_axis_b_tlast),
        .m0_axis_c_tvalid (m0_axis_c_tvalid),
        .m0_axis_c_tready (m0_axis_c_tready),
        .m0_axis_c_tdata  (m0_axis_c_tdata),
        .m0_axis_c_tlast  (m0_axis_c_tlast),
        .s1_axis_a_tvalid (s1_axis_a_tvalid),
        .s1_axis_a_tready (s1_axis_a_tready),
        .s1_axis_a_tdata  (s1_axis_a_tdata),
        .s1_axis_a_tlast  (s1_axis_a_tlast),
        .s1_axis_b_tvalid (s1_axis_b_tvalid),
        .s1_axis_b_tready (s1_axis_b_tready),
        .s1_axis_b_tdata  (s1_axis_b_tdata),
        .s1_axis_b_tlast  (s1_axis_b_tlast),
        .m1_axis_c_tvalid (m1_axis_c_tvalid),
        .m1_axis_c_tready (m1_axis_c_tready),
        .m1_axis_c_tdata  (m1_axis_c_tdata),
        .m1_axis_c_tlast  (m1_axis_c_tlast),
        .m_axis_fa_tvalid (m_axis_fa_tvalid),
        .m_axis_fa_tready (m_axis_fa_tready),
        .m_axis_fa_tdata  (m_axis_fa_tdata),
        .m_axis_fa_tlast  (m_axis_fa_tlast),
        .m_axis_fb_tvalid (m_axis_fb_tvalid),
        .m_axis_fb_tready (m_axis_fb_tready),
        .m_axis_fb_tdata  (m_axis_fb_tdata),
        .m_axis_fb_tlast  (m_axis_fb_tlast),
        .s_axis_fr_tvalid (s_axis_fr_tvalid),
        .s_axis_fr_tready (s_axis_fr_tready),
        .s_axis_fr_tdata  (s_axis_fr_tdata),
        .s_axis_fr_tlast  (s_axis_fr_tlast)
`ifdef VADD_FLOAT_ARBITER_ERR_EN
        ,
        .err              (err)
`endif
    );

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic al; logic bl; } beat_t;
    typedef struct { logic [W-1:0] d; logic l; } res_t;
    typedef struct { logic [W-1:0] d; logic l; int due; } pipe_t;

    beat_t rq0[$], rq1[$];
    res_t  exp0[$], exp1[$];
    res_t  faq[$], fbq[$];
    pipe_t frq[$];
    int    pkt_log[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit fa_rdy, fb_rdy, c0_rdy, c1_rdy;
    bit mm_pending;
    int cnt_fa_v, cnt_req_rdy, n_fa_hs, n_fb_hs, n_res0, n_res1, n_m1_v;
    logic smp_fa_v, smp_fb_v, smp_fr_rdy, smp_m0_v, smp_m1_v;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] i2f(input int n);
        return r2f(real'(n));
    endfunction

    task automatic push_beat(input int r, input logic [31:0] a, input logic [31:0] b,
                             input logic al, input logic bl, input logic [31:0] ed);
        beat_t bt;
        res_t  rs;
        bt = '{a, b, al, bl};
        rs = '{ed, al};
        if (r == 0) begin rq0.push_back(bt); exp0.push_back(rs); end
        else        begin rq1.push_back(bt); exp1.push_back(rs); end
    endtask

    task automatic push_pkt(input int r, input int base, input int n, input int bval);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = i2f(base + i);
            b = i2f(bval);
            push_beat(r, a, b, i == n - 1, i == n - 1, fadd(a, b));
        end
    endtask

    task automatic clr_cnt();
        cnt_fa_v = 0; cnt_req_rdy = 0; n_fa_hs = 0; n_fb_hs = 0;
        n_res0 = 0; n_res1 = 0; n_m1_v = 0;
    endtask

    // One clock cycle: drive after negedge, sample handshakes, advance the adder model at posedge.
    task automatic step();
        beat_t bt;
        res_t  rs, ra, rb;
        logic  hs0, hs1, fah, fbh, frh, c0h, c1h;
        if (rq0.size() > 0) begin
            s0_axis_a_tvalid = 1'b1; s0_axis_b_tvalid = 1'b1;
            s0_axis_a_tdata = rq0[0].a; s0_axis_b_tdata = rq0[0].b;
            s0_axis_a_tlast = rq0[0].al; s0_axis_b_tlast = rq0[0].bl;
        end else begin
            s0_axis_a_tvalid = 1'b0; s0_axis_b_tvalid = 1'b0;
            s0_axis_a_tdata = '0; s0_axis_b_tdata = '0;
            s0_axis_a_tlast = 1'b0; s0_axis_b_tlast = 1'b0;
        end
        if (rq1.size() > 0) begin
            s1_axis_a_tvalid = 1'b1; s1_axis_b_tvalid = 1'b1;
            s1_axis_a_tdata = rq1[0].a; s1_axis_b_tdata = rq1[0].b;
            s1_axis_a_tlast = rq1[0].al; s1_axis_b_tlast = rq1[0].bl;
        end else begin
            s1_axis_a_tvalid = 1'b0; s1_axis_b_tvalid = 1'b0;
            s1_axis_a_tdata = '0; s1_axis_b_tdata = '0;
            s1_axis_a_tlast = 1'b0; s1_axis_b_tlast = 1'b0;
        end
        m_axis_fa_tready = fa_rdy;
        m_axis_fb_tready = fb_rdy;
        m0_axis_c_tready = c0_rdy;
        m1_axis_c_tready = c1_rdy;
        if (frq.size() > 0 && frq[0].due <= cyc) begin
            s_axis_fr_tvalid = 1'b1; s_axis_fr_tdata = frq[0].d; s_axis_fr_tlast = frq[0].l;
        end else begin
            s_axis_fr_tvalid = 1'b0; s_axis_fr_tdata = '0; s_axis_fr_tlast = 1'b0;
        end
        #1;
        smp_fa_v   = m_axis_fa_tvalid;
        smp_fb_v   = m_axis_fb_tvalid;
        smp_fr_rdy = s_axis_fr_tready;
        smp_m0_v   = m0_axis_c_tvalid;
        smp_m1_v   = m1_axis_c_tvalid;
        hs0 = s0_axis_a_tvalid & s0_axis_a_tready;
        hs1 = s1_axis_a_tvalid & s1_axis_a_tready;
        fah = m_axis_fa_tvalid & m_axis_fa_tready;
        fbh = m_axis_fb_tvalid & m_axis_fb_tready;
        frh = s_axis_fr_tvalid & s_axis_fr_tready;
        c0h = m0_axis_c_tvalid & m0_axis_c_tready;
        c1h = m1_axis_c_tvalid & m1_axis_c_tready;
        if (m_axis_fa_tvalid) cnt_fa_v++;
        if (s0_axis_a_tready | s1_axis_a_tready) cnt_req_rdy++;
        if (m1_axis_c_tvalid) n_m1_v++;
`ifdef VADD_FLOAT_ARBITER_ERR_EN
        if (mm_pending) begin
            check_eq("err_after_mismatch", err, 1);
            mm_pending = 1'b0;
        end
`endif
        if (c0h) begin
            check_eq("c_exclusive0", m1_axis_c_tvalid, 0);
            if (exp0.size() == 0) begin
                check_eq("c0_extra_result", exp0.size(), 1);
            end else begin
                rs = exp0.pop_front();
                check_eq("c0_data", m0_axis_c_tdata, rs.d);
                check_eq("c0_last", m0_axis_c_tlast, rs.l);
            end
            n_res0++;
        end
        if (c1h) begin
            if (exp1.size() == 0) begin
                check_eq("c1_extra_result", exp1.size(), 1);
            end else begin
                rs = exp1.pop_front();
                check_eq("c1_data", m1_axis_c_tdata, rs.d);
                check_eq("c1_last", m1_axis_c_tlast, rs.l);
            end
            n_res1++;
        end
        if (hs0 || hs1) begin
            if (hs0) bt = rq0.pop_front();
            else     bt = rq1.pop_front();
            if (bt.al) pkt_log.push_back(hs1 ? 1 : 0);
            if (bt.al != bt.bl) begin
`ifdef VADD_FLOAT_ARBITER_ERR_EN
                check_eq("err_before_mismatch", err, 0);
`endif
                mm_pending = 1'b1;
            end
        end
        if (fah) begin faq.push_back('{m_axis_fa_tdata, m_axis_fa_tlast}); n_fa_hs++; end
        if (fbh) begin fbq.push_back('{m_axis_fb_tdata, m_axis_fb_tlast}); n_fb_hs++; end
        if (frh) frq.delete(0);
        @(posedge ap_aclk);
        cyc++;
        while (faq.size() > 0 && fbq.size() > 0) begin
            ra = faq.pop_front();
            rb = fbq.pop_front();
            frq.push_back('{fadd(ra.d, rb.d), ra.l, cyc + LAT});
        end
        @(negedge ap_aclk);
    endtask

    task automatic do_reset();
        ap_areset = 1'b1;
        rq0.delete(); rq1.delete(); exp0.delete(); exp1.delete();
        faq.delete(); fbq.delete(); frq.delete(); pkt_log.delete();
        mm_pending = 1'b0;
        repeat (2) step();
        ap_areset = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n = 0;
        while ((rq0.size() + rq1.size() + exp0.size() + exp1.size()) > 0 && n < max_cyc) begin
            step();
            n++;
        end
        check_eq({tag, "_drain"}, rq0.size() + rq1.size() + exp0.size() + exp1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ap_areset = 1'b1;
        fa_rdy = 1; fb_rdy = 1; c0_rdy = 1; c1_rdy = 1;
        mm_pending = 1'b0;
        clr_cnt();
        @(negedge ap_aclk);

        // Reset state
        do_reset();
        check_eq("rst_fa_tvalid", smp_fa_v, 0);
        check_eq("rst_fb_tvalid", smp_fb_v, 0);
        check_eq("rst_fr_tready", smp_fr_rdy, 0);
        check_eq("rst_c_tvalid", {smp_m0_v, smp_m1_v}, 0);
        check_eq("rst_req_tready", cnt_req_rdy, 0);
`ifdef VADD_FLOAT_ARBITER_ERR_EN
        check_eq("rst_err", err, 0);
`endif

        // Single requester
        clr_cnt();
        push_beat(0, 32'h3F800000, 32'h3F000000, 0, 0, 32'h3FC00000);
        push_beat(0, 32'h40000000, 32'h3F000000, 0, 0, 32'h40200000);
        push_beat(0, 32'h40400000, 32'h3F000000, 0, 0, 32'h40600000);
        push_beat(0, 32'h40800000, 32'h3F000000, 1, 1, 32'h40900000);
        drain("single", 200);
        check_eq("single_m1_idle", n_m1_v, 0);
        check_eq("single_n_res", n_res0, 4);

        // Contention
        do_reset();
        clr_cnt();
        push_pkt(0, 10, 3, 1);
        push_pkt(0, 20, 3, 1);
        push_pkt(1, 100, 3, 2);
        push_pkt(1, 200, 3, 2);
        drain("contend", 300);
        check_eq("contend_npkt", pkt_log.size(), 4);
        if (pkt_log.size() == 4) begin
            check_eq("contend_g0", pkt_log[0], 0);
            check_eq("contend_g1", pkt_log[1], 1);
            check_eq("contend_g2", pkt_log[2], 0);
            check_eq("contend_g3", pkt_log[3], 1);
        end
        check_eq("contend_nres", {n_res0[15:0], n_res1[15:0]}, {16'd6, 16'd6});

        // Adder backpressure on the b side
        do_reset();
        clr_cnt();
        fb_rdy = 0;
        push_pkt(0, 7, 1, 3);
        repeat (6) step();
        check_eq("bp_fa_valid_cycles", cnt_fa_v, 1);
        check_eq("bp_fa_hs", n_fa_hs, 1);
        check_eq("bp_fb_hs", n_fb_hs, 0);
        check_eq("bp_fb_still_valid", smp_fb_v, 1);
        check_eq("bp_req_tready", cnt_req_rdy, 0);
        fb_rdy = 1;
        drain("bp", 100);
        check_eq("bp_fa_hs_total", n_fa_hs, 1);
        check_eq("bp_fb_hs_total", n_fb_hs, 1);
        check_eq("bp_one_result", n_res0, 1);

        // Tag FIFO full
        do_reset();
        clr_cnt();
        c0_rdy = 0;
        push_pkt(0, 1, 8, 1);
        repeat (30) step();
        check_eq("full_issued", n_fa_hs, 4);
        check_eq("full_fa_stalled", smp_fa_v, 0);
        check_eq("full_no_results", n_res0, 0);
        c0_rdy = 1;
        step();
        check_eq("full_drain_cycle_fa", smp_fa_v, 0);
        check_eq("full_drained_one", n_res0, 1);
        step();
        check_eq("full_resume_fa", smp_fa_v, 1);
        drain("full", 200);
        check_eq("full_all_results", n_res0, 8);

        // Interleaved drain, r1 blocked at the head
        do_reset();
        clr_cnt();
        c1_rdy = 0;
        push_pkt(0, 30, 1, 1);
        push_pkt(1, 40, 1, 1);
        push_pkt(0, 50, 2, 1);
        repeat (25) step();
        check_eq("ilv_r0_first", n_res0, 1);
        check_eq("ilv_r1_held", n_res1, 0);
        check_eq("ilv_fr_tready", smp_fr_rdy, 0);
        check_eq("ilv_m0_no_bypass", smp_m0_v, 0);
        check_eq("ilv_m1_valid", smp_m1_v, 1);
        c1_rdy = 1;
        drain("ilv", 200);
        check_eq("ilv_nres", {n_res0[15:0], n_res1[15:0]}, {16'd3, 16'd1});

        // tlast mismatch: packet end follows a.tlast
        do_reset();
        clr_cnt();
        push_beat(0, i2f(1), i2f(1), 0, 0, fadd(i2f(1), i2f(1)));
        push_beat(0, i2f(2), i2f(1), 1, 0, fadd(i2f(2), i2f(1)));
        push_pkt(0, 3, 1, 1);
        push_pkt(1, 5, 1, 1);
        drain("mm", 200);
        check_eq("mm_npkt", pkt_log.size(), 3);
        if (pkt_log.size() == 3) begin
            check_eq("mm_g0", pkt_log[0], 0);
            check_eq("mm_g1", pkt_log[1], 1);
            check_eq("mm_g2", pkt_log[2], 0);
        end
`ifdef VADD_FLOAT_ARBITER_ERR_EN
        check_eq("mm_err_sticky", err, 1);
        do_reset();
        check_eq("mm_err_cleared", err, 0);
`endif

        // Result with no tag outstanding is held
        do_reset();
        clr_cnt();
        frq.push_back('{32'hDEADBEEF, 1'b1, 0});
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("orphan_fr_tready", smp_fr_rdy, 0);
            check_eq("orphan_c_tvalid", {smp_m0_v, smp_m1_v}, 0);
        end
        check_eq("orphan_kept", frq.size(), 1);
`ifdef VADD_FLOAT_ARBITER_ERR_EN
        check_eq("orphan_err", err, 1);
        do_reset();
        check_eq("orphan_err_cleared", err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
